// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: PC, 2-entry fetched-word FIFO, redirect/flush, fault tagging.
// Latency: a word fetched in cycle N is presented to decode in cycle N+1 (registered FIFO head).
// Backpressure: inst_ready low fills the FIFO to 2 entries, then fetch stalls with pc held.
module fetch_unit #(
  parameter int                      ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = 'h1000,
  parameter int                      MEM_SIZE     = 32'h1000,
  parameter int                      PC_STEP      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDRESS_SIZE-1:0] imem_address,
  input  logic [ADDRESS_SIZE-1:0] imem_instruction,
  input  logic                    redirect,
  input  logic [ADDRESS_SIZE-1:0] redirect_pc,
  input  logic                    inst_ready,
  output logic                    inst_valid,
  output logic [ADDRESS_SIZE-1:0] inst,
  output logic [ADDRESS_SIZE-1:0] inst_pc,
  output logic                    inst_fault
);

  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDRESS =
    BOOT_ADDRESS + ADDRESS_SIZE'(MEM_SIZE) - ADDRESS_SIZE'(4);
  localparam logic [ADDRESS_SIZE-1:0] STEP = ADDRESS_SIZE'(PC_STEP);

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] pc;
    logic [ADDRESS_SIZE-1:0] word;
    logic                    fault;
  } entry_t;

  logic [ADDRESS_SIZE-1:0] pc;
  logic                    halted;

  entry_t                  slot [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;

  logic                    deq;
  logic                    fetch_en;
  logic                    fetch_fault;
  entry_t                  new_entry;
  entry_t                  head;

  assign imem_address = pc;

  // A fetch faults when it lies outside the window or is not word aligned.
  assign fetch_fault = (pc < BOOT_ADDRESS) || (pc > LAST_ADDRESS) || (pc[1:0] != 2'b00);

  assign head       = slot[rd_ptr];
  assign inst_valid = (count != 2'd0);
  assign inst       = head.word;
  assign inst_pc    = head.pc;
  assign inst_fault = head.fault;

  assign deq      = inst_valid & inst_ready;
  assign fetch_en = !halted && !redirect && ((count != 2'd2) || deq);

  always_comb begin
    new_entry       = '0;
    new_entry.pc    = pc;
    new_entry.fault = fetch_fault;
    new_entry.word  = fetch_fault ? '0 : imem_instruction;
  end

  // PC and halt state; a faulting fetch freezes the PC until redirect or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= BOOT_ADDRESS;
      halted <= 1'b0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      halted <= 1'b0;
    end else if (fetch_en) begin
      if (fetch_fault) begin
        halted <= 1'b1;
      end else begin
        pc <= pc + STEP;
      end
    end
  end

  // Two-entry FIFO; redirect discards everything, including a word fetched this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        slot[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (fetch_en) begin
        slot[wr_ptr] <= new_entry;
        wr_ptr       <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({fetch_en, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
